// File: rtl/regfile_wb_ctrl.sv
// Register file write-port owner: sweeps all registers to INIT_VALUE after reset, then drains queued writebacks one per cycle.
// Accepted writes reach the registered write port one cycle later; wb_ready drops only while the writeback queue is full.
module regfile_wb_ctrl #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  output logic        rf_wr_en,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_wrData,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic [31:0] rf_rdData1,
  input  logic [31:0] rf_rdData2,
  output logic [31:0] rdData1,
  output logic [31:0] rdData2,
  output logic        init_done
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [5:0]    init_ptr;
  logic [4:0]    fifo_dest [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic          nxt_wr_en;
  logic [4:0]    nxt_dest;
  logic [31:0]   nxt_data;

  assign wb_ready = (count != FULL_CNT);
  // R0 writes are consumed at the handshake but never occupy a queue slot
  assign push     = wb_valid && wb_ready && (wb_dest != 5'd0);
  assign pop      = (state == S_RUN) && (count != '0);

  always_comb begin
    state_nxt = state;
    nxt_wr_en = 1'b0;
    nxt_dest  = rf_dest;
    nxt_data  = rf_wrData;
    if (state == S_INIT) begin
      nxt_wr_en = 1'b1;
      nxt_dest  = init_ptr[4:0];
      nxt_data  = INIT_VALUE;
      if (init_ptr == 6'd31) state_nxt = S_RUN;
    end else if (pop) begin
      nxt_wr_en = 1'b1;
      nxt_dest  = fifo_dest[rd_ptr];
      nxt_data  = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      init_ptr  <= 6'd0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rf_wr_en  <= 1'b0;
      rf_dest   <= 5'd0;
      rf_wrData <= 32'd0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      rf_wr_en  <= nxt_wr_en;
      rf_dest   <= nxt_dest;
      rf_wrData <= nxt_data;
      if (state == S_INIT) init_ptr <= init_ptr + 6'd1;
      // Address 31 is committed on the first edge spent in RUN
      if (state == S_RUN) init_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= wb_dest;
      fifo_data[wr_ptr] <= wb_data;
    end
  end

  // Scan oldest to newest so the newest matching queue entry wins
  always_comb begin
    rdData1 = 32'd0;
    rdData2 = 32'd0;
    if (state == S_RUN) begin
      rdData1 = rf_rdData1;
      rdData2 = rf_rdData2;
      if (rf_wr_en && rf_dest == src1) rdData1 = rf_wrData;
      if (rf_wr_en && rf_dest == src2) rdData2 = rf_wrData;
      for (int i = 0; i < DEPTH; i++) begin
        if ((AW+1)'(i) < count) begin
          if (fifo_dest[rd_ptr + AW'(i)] == src1) rdData1 = fifo_data[rd_ptr + AW'(i)];
          if (fifo_dest[rd_ptr + AW'(i)] == src2) rdData2 = fifo_data[rd_ptr + AW'(i)];
        end
      end
      if (src1 == 5'd0) rdData1 = 32'd0;
      if (src2 == 5'd0) rdData2 = 32'd0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized scoreboard bench for regfile_wb_ctrl with an attached register file model.
module tb_regfile_wb_ctrl;

  localparam int          DEPTH      = 4;
  localparam logic [31:0] INIT_VALUE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_dest = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [4:0]  src1 = 5'd0;
  logic [4:0]  src2 = 5'd0;
  logic        wb_ready, rf_wr_en, init_done;
  logic [4:0]  rf_dest;
  logic [31:0] rf_wrData, rf_rdData1, rf_rdData2, rdData1, rdData2;

  regfile_wb_ctrl #(.DEPTH(DEPTH), .INIT_VALUE(INIT_VALUE)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
    .rf_wr_en(rf_wr_en), .rf_dest(rf_dest), .rf_wrData(rf_wrData),
    .src1(src1), .src2(src2), .rf_rdData1(rf_rdData1), .rf_rdData2(rf_rdData2),
    .rdData1(rdData1), .rdData2(rdData2), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    int          acc;
  } wr_t;

  wr_t         q[$];
  logic [31:0] arch [32];
  logic [31:0] rf_mem [32];
  int          cyc = -1;
  int          total = 0;
  int          bad = 0;
  logic        accepted;
  logic [4:0]  exp_dest;
  logic [31:0] exp_data;
  wr_t         e;

  // Register file without reset: powers up with garbage and has no hardwired R0
  always @(posedge clk) begin
    if (cyc < 0) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= $urandom;
    end else if (rf_wr_en) begin
      rf_mem[rf_dest] <= rf_wrData;
    end
  end
  assign rf_rdData1 = (src1 == 5'd0) ? 32'hFFFF_FFFF : rf_mem[src1];
  assign rf_rdData2 = (src2 == 5'd0) ? 32'hFFFF_FFFF : rf_mem[src2];

  // Cycle k is the cycle after the k-th edge following the last reset edge
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else if (cyc >= 0) cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 0) begin
      if (cyc == 0) begin
        chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rst_dest", 32'(rf_dest), 32'd0);
        chk("rst_data", rf_wrData, 32'd0);
        exp_dest = 5'd0;
        exp_data = 32'd0;
      end else if (cyc <= 32) begin
        chk("sweep_wr_en", 32'(rf_wr_en), 32'd1);
        chk("sweep_dest", 32'(rf_dest), 32'(cyc - 1));
        chk("sweep_data", rf_wrData, INIT_VALUE);
        exp_dest = 5'(cyc - 1);
        exp_data = INIT_VALUE;
      end else if (q.size() > 0 && q[0].acc < cyc) begin
        e = q.pop_front();
        chk("drain_wr_en", 32'(rf_wr_en), 32'd1);
        chk("drain_dest", 32'(rf_dest), 32'(e.dest));
        chk("drain_data", rf_wrData, e.data);
        exp_dest = e.dest;
        exp_data = e.data;
      end else begin
        chk("idle_wr_en", 32'(rf_wr_en), 32'd0);
        chk("hold_dest", 32'(rf_dest), 32'(exp_dest));
        chk("hold_data", rf_wrData, exp_data);
      end
      chk("init_done", 32'(init_done), 32'(cyc >= 33));
      chk("wb_ready", 32'(wb_ready), 32'(q.size() < DEPTH));
      chk("rdData1", rdData1, (cyc < 32 || src1 == 5'd0) ? 32'd0 : arch[src1]);
      chk("rdData2", rdData2, (cyc < 32 || src2 == 5'd0) ? 32'd0 : arch[src2]);
    end
  end

  // Inputs change just after the falling edge and are taken at the next rising edge
  task automatic drive(input logic r, input logic v, input logic [4:0] d, input logic [31:0] dat);
    wr_t w;
    @(negedge clk);
    #1;
    rst      = r;
    wb_valid = v;
    wb_dest  = d;
    wb_data  = dat;
    accepted = 1'b0;
    if (r) begin
      q.delete();
      for (int i = 0; i < 32; i++) arch[i] = INIT_VALUE;
    end else if (v && wb_ready) begin
      accepted = 1'b1;
      if (d != 5'd0) begin
        w.dest = d;
        w.data = dat;
        w.acc  = cyc + 1;
        q.push_back(w);
        arch[d] = dat;
      end
    end
  endtask

  task automatic send(input logic [4:0] d, input logic [31:0] dat);
    int n;
    n = 0;
    do begin
      drive(1'b0, 1'b1, d, dat);
      n++;
    end while (!accepted && n < 100);
    total++;
    if (!accepted) begin
      bad++;
      $display("FAIL send_timeout dest=%0d got=not_accepted want=accepted", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 5'($urandom), $urandom);
  endtask

  task automatic random_traffic(input int n);
    repeat (n) begin
      drive(1'b0, ($urandom % 3) != 0,
            ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom % 8), $urandom);
      src1 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom % 8);
      src2 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom % 8);
    end
  endtask

  initial begin
    int n;
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0);

    // Fill the queue during the sweep, including two writes to R7
    src1 = 5'd7;
    src2 = 5'd1;
    send(5'd1, 32'hA000_0001);
    send(5'd7, 32'd1);
    send(5'd7, 32'd2);
    send(5'd4, 32'hA000_0004);
    send(5'd9, 32'hA000_0009);
    idle(6);

    src1 = 5'd5;
    send(5'd5, 32'hDEAD_BEEF);
    idle(4);

    src2 = 5'd0;
    send(5'd0, 32'h0000_1234);
    idle(3);

    random_traffic(800);
    idle(5);

    // Reset with three entries still queued after the sweep
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    src1 = 5'd3;
    src2 = 5'd6;
    send(5'd3, 32'hB000_0003);
    send(5'd6, 32'hB000_0006);
    send(5'd3, 32'hB000_0033);
    send(5'd8, 32'hB000_0008);
    n = 0;
    while (cyc < 32 && n < 100) begin
      idle(1);
      n++;
    end
    total++;
    if (cyc != 32) begin
      bad++;
      $display("FAIL reach_run got=%0d want=32", cyc);
    end
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    idle(40);
    random_traffic(300);
    idle(10);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL final_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-side controller that owns the register file's write port (wr_en/dest/wrData) and serves as the pipeline's writeback front end.
- After reset, it sweeps all 32 registers to INIT_VALUE, because the register file itself has no reset.
- Writebacks from the MEM/WB stage are queued in a small FIFO and drained one per cycle; writes to R0 are dropped.
- It provides bypassed read data so that operand reads see writes still pending in the queue.

Parameters:
DEPTH, 4, writeback FIFO entries (power of two, >=2)
INIT_VALUE, 32'h0000_0000, value written to every register during the init sweep

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
wb_valid  input  1  writeback request valid
wb_ready  output  1  controller can accept a request this cycle
wb_dest  input  5  writeback destination register
wb_data  input  32  writeback data
rf_wr_en  output  1  register file write enable (registered)
rf_dest  output  5  register file destination address (registered)
rf_wrData  output  32  register file write data (registered)
src1  input  5  read address 1, also driven to the register file
src2  input  5  read address 2, also driven to the register file
rf_rdData1  input  32  raw register file read data 1
rf_rdData2  input  32  raw register file read data 2
rdData1  output  32  bypassed read data 1
rdData2  output  32  bypassed read data 2
init_done  output  1  high once the init sweep has completed

Behaviour:
Reset (rst high at a clock edge, dominant over everything):
- state=INIT, init_ptr=0, FIFO emptied.
- rf_wr_en=0, rf_dest=0, rf_wrData=0, init_done=0.
- A reset mid-sweep or mid-drain discards all queued writes and restarts the sweep from 0.

State INIT:
- Each cycle, the output register loads rf_wr_en=1, rf_dest=init_ptr, rf_wrData=INIT_VALUE; then init_ptr increments.
- Sweep covers addresses 0..31, so rf_wr_en is high for exactly 32 consecutive cycles starting the cycle after rst deasserts.
- When the entry for address 31 is loaded, state goes to RUN. init_done rises in the same cycle the register file commits address 31.
- FIFO does not pop during INIT; requests are still accepted while wb_ready is high.

State RUN:
- Each cycle, if the FIFO is non-empty, pop the head into the output register (rf_wr_en=1, rf_dest/rf_wrData = entry); otherwise rf_wr_en=0.
- rf_dest/rf_wrData hold their previous values when rf_wr_en=0.

Accept rules:
- wb_ready = !FIFO full (combinational from count only).
- A request is accepted on an edge where wb_valid && wb_ready.
- An accepted request with wb_dest=0 is consumed but not queued.
- Push and pop in the same cycle are both allowed; count is unchanged.
- A push while full cannot occur because wb_ready=0.

Latency:
- In RUN with an empty FIFO, a request accepted at edge N has rf_wr_en=1 in cycle N+1..N+2, and the register file commits at edge N+2.
- Sustained throughput is 1 write per cycle.

Bypass (combinational, per read port, shown for port 1):
- If src1 == 0: rdData1 = 0.
- Else if any valid FIFO entry has dest == src1: the newest matching entry's data.
- Else if rf_wr_en && rf_dest == src1: rf_wrData.
- Else: rf_rdData1.
- During INIT, rdData1/rdData2 are 0 (consumers must wait for init_done).

Arithmetic:
- FIFO pointers wrap modulo DEPTH.
- Count is log2(DEPTH)+1 bits.
- init_ptr is 6 bits; the terminal value is 31.

Test Plan:
1. Reset: rst high 2 cycles then low -> rf_wr_en high 32 consecutive cycles with rf_dest 0..31 and rf_wrData=0; init_done=1 after the last write; rf_wr_en=0 afterwards.
2. Write plus forward: in RUN, push dest=5 data=32'hDEADBEEF; hold src1=5 with rf_rdData1=32'h1111 -> rdData1=32'hDEADBEEF from the cycle after acceptance; rf_wr_en/rf_dest=5 exactly one cycle; afterwards rdData1 follows rf_rdData1.
3. R0 drop: push dest=0 data=32'h1234 -> wb_ready=1 and the request is consumed, no rf_wr_en pulse; src2=0 -> rdData2=0 even with rf_rdData2=32'hFFFF_FFFF.
4. Full/backpressure: during INIT, push 4 requests (dest 1..4) -> wb_ready=0 after the 4th; after init completes they drain on 4 consecutive cycles in order 1,2,3,4 and wb_ready returns to 1.
5. Newest-wins: queue dest=7 data=1, then dest=7 data=2 during INIT; src1=7 after init_done -> rdData1=2, including the cycle where rf_dest=7 carries 1.
6. Reset mid-operation: assert rst with 3 entries queued in RUN -> no further queued writes appear; the 32-write sweep restarts from address 0; wb_ready=1 with the FIFO empty.
